// File: rtl/game_pkg.sv
//==============================================================================
// Module      : game_pkg
// Description : Shared screen constants, coordinate type and bullet states.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package game_pkg;

    localparam int H_RES = 640;
    localparam int V_RES = 480;

    typedef logic [15:0] coord_t;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        FLYING = 1'b1
    } bullet_state_e;

endpackage

`default_nettype wire

// File: rtl/edge_sync.sv
//==============================================================================
// Module      : edge_sync
// Description : Two-flop synchronizer for an active-low async input, followed
//               by a one-cycle pulse on its synchronized falling edge.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module edge_sync (
    input  logic clk_pix,
    input  logic rst_n,
    input  logic async_n,
    output logic fall_pulse
);

    logic r_meta;
    logic r_sync;
    logic r_prev;

    // Idle-high reset so a button already released never looks like a press.
    always_ff @(posedge clk_pix or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= 1'b1;
            r_sync <= 1'b1;
            r_prev <= 1'b1;
        end else begin
            r_meta <= async_n;
            r_sync <= r_meta;
            r_prev <= r_sync;
        end
    end

    assign fall_pulse = r_prev & ~r_sync;

endmodule

`default_nettype wire

// File: rtl/ship_motion.sv
//==============================================================================
// Module      : ship_motion
// Description : Converts tilt samples into a per-frame ship x position and runs
//               the player's single bullet.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module ship_motion
    import game_pkg::*;
#(
    parameter int SHIP_W       = 17,
    parameter int SHIP_X_INIT  = 220,
    parameter int SHIP_Y_INIT  = 140,
    parameter int DEADZONE     = 16,
    parameter int SHIFT        = 4,
    parameter int MAX_STEP     = 8,
    parameter int BULLET_SPEED = 4,
    parameter int BULLET_H     = 4
) (
    input  logic        clk_pix,
    input  logic        rst_n,
    input  logic        frame,
    input  logic [15:0] accel_x,
    input  logic        accel_valid,
    input  logic        fire_n,
    output logic [15:0] ship_x,
    output logic [15:0] ship_y,
    output logic [15:0] bullet_x,
    output logic [15:0] bullet_y,
    output logic        bullet_active
);

    localparam coord_t              c_ship_x_init = coord_t'(SHIP_X_INIT);
    localparam coord_t              c_ship_y      = coord_t'(SHIP_Y_INIT);
    localparam coord_t              c_deadzone    = coord_t'(DEADZONE);
    localparam coord_t              c_max_step    = coord_t'(MAX_STEP);
    localparam coord_t              c_half_w      = coord_t'(SHIP_W / 2);
    localparam coord_t              c_launch_y    = coord_t'(SHIP_Y_INIT - BULLET_H);
    localparam coord_t              c_speed       = coord_t'(BULLET_SPEED);
    localparam logic signed [16:0]  c_x_max       = 17'(H_RES - SHIP_W);

    // Saturating magnitude keeps -32768 from folding back to a negative value.
    function automatic coord_t calc_step(input logic signed [15:0] tilt);
        coord_t mag;
        coord_t excess;
        if (tilt == 16'sh8000)
            mag = 16'h7FFF;
        else if (tilt[15])
            mag = coord_t'(-tilt);
        else
            mag = coord_t'(tilt);
        if (mag <= c_deadzone)
            return 16'd0;
        excess = (mag - c_deadzone) >> SHIFT;
        return (excess > c_max_step) ? c_max_step : excess;
    endfunction

    logic signed [15:0] r_tilt;
    coord_t             r_ship_x;
    coord_t             r_bullet_x;
    coord_t             r_bullet_y;
    logic               r_pending;
    bullet_state_e      r_state;

    bullet_state_e      w_state_next;
    logic               w_fire_pulse;
    logic               w_launch;
    logic               w_land;
    logic               w_advance;
    coord_t             w_step;
    logic signed [16:0] w_sum;
    coord_t             w_ship_next;

    edge_sync u_fire_sync (
        .clk_pix    (clk_pix),
        .rst_n      (rst_n),
        .async_n    (fire_n),
        .fall_pulse (w_fire_pulse)
    );

    always_ff @(posedge clk_pix or negedge rst_n) begin
        if (!rst_n)
            r_tilt <= 16'sd0;
        else if (accel_valid)
            r_tilt <= accel_x;
    end

    // 17-bit signed arithmetic so stepping below zero clamps instead of wrapping.
    always_comb begin
        w_step = calc_step(r_tilt);
        if (r_tilt[15])
            w_sum = $signed({1'b0, r_ship_x}) - $signed({1'b0, w_step});
        else
            w_sum = $signed({1'b0, r_ship_x}) + $signed({1'b0, w_step});
        if (w_sum < 17'sd0)
            w_ship_next = 16'd0;
        else if (w_sum > c_x_max)
            w_ship_next = c_x_max[15:0];
        else
            w_ship_next = w_sum[15:0];
    end

    always_ff @(posedge clk_pix or negedge rst_n) begin
        if (!rst_n)
            r_ship_x <= c_ship_x_init;
        else if (frame)
            r_ship_x <= w_ship_next;
    end

    always_ff @(posedge clk_pix or negedge rst_n) begin
        if (!rst_n)
            r_state <= IDLE;
        else
            r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (frame && r_pending) w_state_next = FLYING;
            FLYING:  if (frame && (r_bullet_y < c_speed)) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_comb begin
        w_launch  = 1'b0;
        w_land    = 1'b0;
        w_advance = 1'b0;
        case (r_state)
            IDLE:    w_launch = frame && r_pending;
            FLYING: begin
                w_land    = frame && (r_bullet_y < c_speed);
                w_advance = frame && !(r_bullet_y < c_speed);
            end
            default: ;
        endcase
    end

    // Presses during flight are dropped; only an idle bullet can be armed.
    always_ff @(posedge clk_pix or negedge rst_n) begin
        if (!rst_n)
            r_pending <= 1'b0;
        else if (w_launch)
            r_pending <= 1'b0;
        else if (w_fire_pulse && (r_state == IDLE))
            r_pending <= 1'b1;
    end

    always_ff @(posedge clk_pix or negedge rst_n) begin
        if (!rst_n) begin
            r_bullet_x <= 16'd0;
            r_bullet_y <= 16'd0;
        end else if (w_launch) begin
            r_bullet_x <= r_ship_x + c_half_w;
            r_bullet_y <= c_launch_y;
        end else if (w_advance) begin
            r_bullet_y <= r_bullet_y - c_speed;
        end
    end

    assign ship_x        = r_ship_x;
    assign ship_y        = c_ship_y;
    assign bullet_x      = r_bullet_x;
    assign bullet_y      = r_bullet_y;
    assign bullet_active = (r_state == FLYING);

endmodule

`default_nettype wire

// File: tb/tb_ship_motion.sv
//==============================================================================
// Module      : tb_ship_motion
// Description : Directed self-checking bench for ship_motion.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_ship_motion;

    logic        clk_pix;
    logic        rst_n;
    logic        frame;
    logic [15:0] accel_x;
    logic        accel_valid;
    logic        fire_n;
    logic [15:0] ship_x;
    logic [15:0] ship_y;
    logic [15:0] bullet_x;
    logic [15:0] bullet_y;
    logic        bullet_active;

    int n_total;
    int n_pass;

    ship_motion dut (
        .clk_pix       (clk_pix),
        .rst_n         (rst_n),
        .frame         (frame),
        .accel_x       (accel_x),
        .accel_valid   (accel_valid),
        .fire_n        (fire_n),
        .ship_x        (ship_x),
        .ship_y        (ship_y),
        .bullet_x      (bullet_x),
        .bullet_y      (bullet_y),
        .bullet_active (bullet_active)
    );

    initial clk_pix = 1'b0;
    always #5 clk_pix = ~clk_pix;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    task automatic strobe(input logic [15:0] val);
        @(negedge clk_pix);
        accel_x     = val;
        accel_valid = 1'b1;
        @(negedge clk_pix);
        accel_valid = 1'b0;
    endtask

    task automatic frames(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk_pix);
            frame = 1'b1;
            @(negedge clk_pix);
            frame = 1'b0;
        end
    endtask

    task automatic do_reset();
        @(negedge clk_pix);
        rst_n = 1'b0;
        repeat (2) @(negedge clk_pix);
        rst_n = 1'b1;
    endtask

    task automatic press(input int cycles);
        @(negedge clk_pix);
        fire_n = 1'b0;
        repeat (cycles) @(negedge clk_pix);
        fire_n = 1'b1;
        repeat (4) @(negedge clk_pix);
    endtask

    initial begin
        n_total     = 0;
        n_pass      = 0;
        rst_n       = 1'b0;
        frame       = 1'b0;
        accel_x     = 16'd0;
        accel_valid = 1'b0;
        fire_n      = 1'b1;
        do_reset();

        @(negedge clk_pix);
        chk("reset_ship_x", ship_x, 16'd220);
        chk("reset_ship_y", ship_y, 16'd140);
        chk("reset_bullet_active", {15'd0, bullet_active}, 16'd0);
        chk("reset_bullet_x", bullet_x, 16'd0);
        chk("reset_bullet_y", bullet_y, 16'd0);

        // Sample arriving with the frame is not used until the next frame.
        @(negedge clk_pix);
        accel_x = 16'd64; accel_valid = 1'b1; frame = 1'b1;
        @(negedge clk_pix);
        accel_valid = 1'b0; frame = 1'b0;
        chk("same_cycle_sample_ignored", ship_x, 16'd220);
        frames(1);
        chk("tilt64_step3", ship_x, 16'd223);

        strobe(16'd10);
        frames(1);
        chk("deadzone_hold", ship_x, 16'd223);

        strobe(16'hFC18);  // -1000
        frames(5);
        chk("neg_capped_5_frames", ship_x, 16'd183);

        strobe(16'h8000);  // -32768
        frames(22);
        chk("neg_min_22_frames", ship_x, 16'd7);
        frames(8);
        chk("clamp_low_no_wrap", ship_x, 16'd0);

        strobe(16'd1000);
        frames(77);
        chk("pos_77_frames", ship_x, 16'd616);
        frames(1);
        chk("clamp_high", ship_x, 16'd623);
        frames(3);
        chk("clamp_high_hold", ship_x, 16'd623);

        do_reset();
        chk("reset_after_motion", ship_x, 16'd220);

        press(10);
        chk("no_launch_before_frame", {15'd0, bullet_active}, 16'd0);
        frames(1);
        chk("launch_active", {15'd0, bullet_active}, 16'd1);
        chk("launch_x", bullet_x, 16'd228);
        chk("launch_y", bullet_y, 16'd136);
        press(10);
        frames(33);
        chk("fly_33_y", bullet_y, 16'd4);
        frames(1);
        chk("fly_34_y", bullet_y, 16'd0);
        chk("fly_34_active", {15'd0, bullet_active}, 16'd1);
        frames(1);
        chk("landed_active", {15'd0, bullet_active}, 16'd0);
        chk("landed_y_hold", bullet_y, 16'd0);
        chk("landed_x_hold", bullet_x, 16'd228);
        frames(3);
        chk("flight_press_dropped", {15'd0, bullet_active}, 16'd0);

        // Press whose synchronized edge lands in the frame cycle.
        strobe(16'd64);
        @(negedge clk_pix);
        fire_n = 1'b0;
        repeat (2) @(negedge clk_pix);
        frame = 1'b1;
        @(negedge clk_pix);
        frame = 1'b0;
        chk("same_cycle_press_no_launch", {15'd0, bullet_active}, 16'd0);
        chk("same_cycle_ship_moved", ship_x, 16'd223);
        frames(1);
        fire_n = 1'b1;
        chk("late_launch_active", {15'd0, bullet_active}, 16'd1);
        chk("late_launch_old_ship_x", bullet_x, 16'd231);
        chk("late_launch_ship_x", ship_x, 16'd226);

        // Asynchronous reset mid-flight.
        @(posedge clk_pix);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_active", {15'd0, bullet_active}, 16'd0);
        chk("async_rst_ship_x", ship_x, 16'd220);
        chk("async_rst_bullet_x", bullet_x, 16'd0);
        chk("async_rst_bullet_y", bullet_y, 16'd0);
        @(negedge clk_pix);
        rst_n = 1'b1;

        // Pending fire is lost across reset.
        press(5);
        do_reset();
        frames(1);
        chk("pending_lost_on_reset", {15'd0, bullet_active}, 16'd0);
        chk("tilt_cleared_on_reset", ship_x, 16'd220);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
